branch_resolve_pipe: RTL and testbench
======================================

Name: branch_resolve_pipe

Overview:
- Parametrised 2-stage branch resolution unit for the BATAGE-BFNP core. Evaluates all six RV32/RV64 conditional-branch conditions (BEQ/BNE/BLT/BGE/BLTU/BGEU) and compares the outcome against the front-end predicted direction.
- Returns taken, mispredict and tag to the predictor update and redirect logic, with valid/ready backpressure and flush.

Parameters:
- XLEN, 32, operand width in bits (>=8).
- TAG_W, 6, branch tag / ROB-id width carried alongside each branch.
- CNT_W, 32, performance counter width; used only with the optional feature.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  branch operands valid.
- in_ready  out  1  unit can accept a branch this cycle.
- in_rs1  in  XLEN  operand A.
- in_rs2  in  XLEN  operand B.
- in_funct3  in  3  branch funct3.
- in_pred_taken  in  1  predicted direction from front end.
- in_tag  in  TAG_W  branch tag.
- flush  in  1  kill all in-flight branches.
- out_valid  out  1  resolved branch valid.
- out_ready  in  1  consumer accepts the result.
- out_taken  out  1  actual direction.
- out_mispredict  out  1  out_taken != predicted direction.
- out_illegal  out  1  funct3 was 010 or 011.
- out_tag  out  TAG_W  tag of resolved branch.
- perf_clr  in  1  clear counters (present only with the feature).
- perf_resolved  out  CNT_W  resolved-branch count (feature only).
- perf_mispred  out  CNT_W  mispredict count (feature only).

Behaviour:
- Reset:
  - Synchronous, active-low.
  - All valid bits 0, out_valid=0.
  - out_taken, out_mispredict and out_illegal are 0; out_tag is 0.
  - Counters are 0.
- Stage S1 (registered on accept):
  - Captures eq=(rs1==rs2).
  - Captures lts=$signed(rs1)<$signed(rs2) and ltu=rs1<rs2, at full XLEN width.
  - Also captures funct3, pred_taken and tag.
- Stage S2 (output register), taken decode:
  - 000 -> eq; 001 -> !eq.
  - 100 -> lts; 101 -> !lts.
  - 110 -> ltu; 111 -> !ltu.
  - 010/011 -> taken=0, mispredict=0, illegal=1.
- mispredict = taken ^ pred_taken for legal funct3.
- Latency: exactly 2 cycles from the in handshake to out_valid when there is no backpressure. Throughput is 1 branch per cycle.
- Handshake:
  - Input transfers when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
  - out_valid and all out_* fields hold stable while out_valid && !out_ready.
- Pipeline advance:
  - S2 loads from S1 when !s2_valid || out_ready.
  - S1 loads from input when !s1_valid || S1 is advancing.
  - in_ready = !s1_valid || (!s2_valid || out_ready). This path is combinational from out_ready.
- Full pipeline with out_ready=0: in_ready=0; no data is lost or overwritten.
- Flush:
  - Clears s1_valid and s2_valid on the next edge.
  - Highest priority: an input accepted in the same cycle is discarded.
  - An output that handshakes in the flush cycle counts as delivered.
  - in_ready is unaffected by flush.
- Reset mid-operation: in-flight branches are dropped and no output is produced for them.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- Defined:
  - perf_clr, perf_resolved and perf_mispred ports exist.
  - Each output handshake increments perf_resolved; perf_mispred also increments if out_mispredict.
  - Both counters saturate at all-ones.
  - perf_clr zeroes both counters and takes priority over a same-cycle increment.
- Undefined: the three ports and the counters are absent; datapath behaviour is identical.

Decomposition:
- Package bru_pkg:
  - funct3 localparams F3_BEQ=3'b000, F3_BNE=3'b001, F3_BLT=3'b100, F3_BGE=3'b101, F3_BLTU=3'b110, F3_BGEU=3'b111.
  - Packed struct bru_s1_t {eq, lts, ltu, funct3, pred_taken}; the tag is kept outside the struct.
- Sub-module bru_cond_decode: combinational {eq, lts, ltu, funct3} -> {taken, illegal}, instantiated in S2.

Test Plan:
- All funct3 values with rs1=32'hFFFF_FFFF, rs2=32'h0000_0001:
  - BLT taken=1, BLTU taken=0, BGE taken=0, BGEU taken=1, BEQ taken=0, BNE taken=1.
  - Each result arrives exactly 2 cycles after accept.
- Back-to-back stream of 8 branches with out_ready=1:
  - out_valid is continuous.
  - Tags come out in order 0..7.
  - Mispredict is set only where pred_taken differs from the actual direction.
- Backpressure: hold out_ready=0 for 4 cycles while in_valid=1.
  - in_ready drops after 2 accepts.
  - Outputs stay stable while stalled.
  - After release, both results drain in order with no loss.
- Flush with S1 and S2 both valid plus a same-cycle input:
  - Next cycle out_valid=0.
  - No stale tag ever appears.
  - A new branch issued afterwards resolves normally.
- funct3=3'b010 -> out_illegal=1, out_taken=0, out_mispredict=0 even with pred_taken=1.
- With BRU_PERF_CNT_EN and CNT_W=4:
  - 20 mispredicting branches -> both counters saturate at 4'hF.
  - perf_clr asserted together with a handshake -> both counters read 0.
- Reset asserted mid-stream -> all outputs are 0 on the next edge.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolution pipe: funct3 encodings of the
// RV conditional branches, the S1 pipeline record, and a legality helper.
package bru_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Compare results and control captured at S1; the tag travels separately
  // so its width can stay a module parameter.
  typedef struct packed {
    logic       eq;
    logic       lts;
    logic       ltu;
    logic [2:0] funct3;
    logic       pred_taken;
  } bru_s1_t;

  // Only 010 and 011 are unused in the branch major opcode.
  function automatic logic f3_is_legal(input logic [2:0] f3);
    return f3[2:1] != 2'b01;
  endfunction

endpackage

// File: rtl/bru_cond_decode.sv
// Combinational branch condition decode: selects the taken direction from the
// pre-computed compare flags according to funct3 and flags unused encodings.
module bru_cond_decode
  import bru_pkg::*;
(
  input  logic       eq,
  input  logic       lts,
  input  logic       ltu,
  input  logic [2:0] funct3,
  output logic       taken,
  output logic       illegal
);

  // Direction select; illegal encodings never report taken.
  always_comb begin
    taken   = 1'b0;
    illegal = !f3_is_legal(funct3);
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lts;
      F3_BGE:  taken = !lts;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_pipe.sv
// Two-stage branch resolution unit. S1 registers the operand compares, S2
// decodes the direction, compares it with the prediction and holds the
// result under valid/ready backpressure. Flush kills everything in flight.
// Optional performance counters are built when BRU_PERF_CNT_EN is defined.
module branch_resolve_pipe
  import bru_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic             in_pred_taken,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
`ifdef BRU_PERF_CNT_EN
  ,
  input  logic             perf_clr,
  output logic [CNT_W-1:0] perf_resolved,
  output logic [CNT_W-1:0] perf_mispred
`endif
);

  if (XLEN < 8 || TAG_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("branch_resolve_pipe: XLEN must be >= 8, TAG_W and CNT_W >= 1");
  end

  logic                    adv_p2;
  logic                    acc_p0;
  logic                    vld_p1;
  logic                    vld_p2;
  logic signed [XLEN-1:0]  rs1_p0;
  logic signed [XLEN-1:0]  rs2_p0;
  logic                    eq_p0;
  logic                    lts_p0;
  logic                    ltu_p0;
  bru_s1_t                 s1_p1;
  logic [TAG_W-1:0]        tag_p1;
  logic                    taken_p1;
  logic                    illegal_p1;
  logic                    mispred_p1;

  // S2 frees up when empty or when its result is being taken this cycle;
  // in_ready is therefore combinational from out_ready.
  assign adv_p2   = !vld_p2 || out_ready;
  assign in_ready = !vld_p1 || adv_p2;
  assign acc_p0   = in_valid && in_ready;
  assign out_valid = vld_p2;

  // ---- P0: full-width compares on the incoming operands ----
  assign rs1_p0 = in_rs1;
  assign rs2_p0 = in_rs2;
  assign eq_p0  = in_rs1 == in_rs2;
  assign lts_p0 = rs1_p0 < rs2_p0;
  assign ltu_p0 = in_rs1 < in_rs2;

  // Valid bits: flush outranks any advance, so a same-cycle accept is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv_p2)   vld_p2 <= vld_p1;
      if (in_ready) vld_p1 <= in_valid;
    end
  end

  // ---- P1: compare flags and branch control registered on accept ----
  // Data only; its validity is carried by vld_p1.
  always_ff @(posedge clk) begin
    if (acc_p0) begin
      s1_p1.eq         <= eq_p0;
      s1_p1.lts        <= lts_p0;
      s1_p1.ltu        <= ltu_p0;
      s1_p1.funct3     <= in_funct3;
      s1_p1.pred_taken <= in_pred_taken;
      tag_p1           <= in_tag;
    end
  end

  bru_cond_decode u_decode (
    .eq      (s1_p1.eq),
    .lts     (s1_p1.lts),
    .ltu     (s1_p1.ltu),
    .funct3  (s1_p1.funct3),
    .taken   (taken_p1),
    .illegal (illegal_p1)
  );

  // An illegal encoding resolves not-taken and is never a mispredict.
  assign mispred_p1 = !illegal_p1 && (taken_p1 ^ s1_p1.pred_taken);

  // ---- P2: output register, held while the consumer stalls ----
  // Output fields are cleared on reset so the interface idles at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_taken      <= 1'b0;
      out_mispredict <= 1'b0;
      out_illegal    <= 1'b0;
      out_tag        <= '0;
    end else if (adv_p2 && vld_p1 && !flush) begin
      out_taken      <= taken_p1;
      out_mispredict <= mispred_p1;
      out_illegal    <= illegal_p1;
      out_tag        <= tag_p1;
    end
  end

`ifdef BRU_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic out_fire;
  assign out_fire = vld_p2 && out_ready;

  // Saturating counters of delivered results; clear wins over an increment.
  always_ff @(posedge clk) begin
    if (!rst_n || perf_clr) begin
      perf_resolved <= '0;
      perf_mispred  <= '0;
    end else if (out_fire) begin
      perf_resolved <= sat_inc(perf_resolved);
      if (out_mispredict) perf_mispred <= sat_inc(perf_mispred);
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_pipe.sv
// Self-checking bench for branch_resolve_pipe: a table of directed vectors,
// a random back-to-back stream, and hand sequences for backpressure, flush
// and mid-stream reset. A negedge monitor scores every output handshake
// against a queue of expected results pushed at each accepted input.
module tb_branch_resolve_pipe;
  localparam int XLEN  = 32;
  localparam int TAG_W = 6;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [2:0]       in_funct3;
  logic             in_pred_taken;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             out_taken;
  logic             out_mispredict;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;
`ifdef BRU_PERF_CNT_EN
  logic             perf_clr;
  logic [CNT_W-1:0] perf_resolved;
  logic [CNT_W-1:0] perf_mispred;
`endif

  always #5 clk = ~clk;

  branch_resolve_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_funct3      (in_funct3),
    .in_pred_taken  (in_pred_taken),
    .in_tag         (in_tag),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_taken      (out_taken),
    .out_mispredict (out_mispredict),
    .out_illegal    (out_illegal),
    .out_tag        (out_tag)
`ifdef BRU_PERF_CNT_EN
    ,
    .perf_clr       (perf_clr),
    .perf_resolved  (perf_resolved),
    .perf_mispred   (perf_mispred)
`endif
  );

  typedef struct {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [2:0]      f3;
    logic            pred;
    logic            taken;
    logic            ill;
    logic            mis;
  } vec_t;

  typedef struct {
    logic             taken;
    logic             ill;
    logic             mis;
    logic [TAG_W-1:0] tag;
    int               acc_cyc;
    bit               lat;
  } exp_t;

  vec_t       vecs[15];
  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         ncyc = 0;
  int         vld_run = 0;
  int         max_run = 0;
  int         acc_cnt = 0;
  logic [2:0] cur_exp = 3'b000;
  bit         lat_chk = 1'b0;
  logic [2:0] legal_f3[6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference direction: returns {taken, illegal, mispredict}.
  function automatic logic [2:0] model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                       input logic [2:0] f3, input logic pred);
    logic t;
    logic il;
    t  = 1'b0;
    il = 1'b0;
    case (f3)
      3'b000: t = (a == b);
      3'b001: t = (a != b);
      3'b100: t = ($signed(a) < $signed(b));
      3'b101: t = ($signed(a) >= $signed(b));
      3'b110: t = (a < b);
      3'b111: t = (a >= b);
      default: il = 1'b1;
    endcase
    return {t, il, il ? 1'b0 : (t ^ pred)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [2:0] f3,
                       input logic p, input logic [TAG_W-1:0] t, input logic [2:0] e);
    in_rs1        = a;
    in_rs2        = b;
    in_funct3     = f3;
    in_pred_taken = p;
    in_tag        = t;
    cur_exp       = e;
    in_valid      = 1'b1;
  endtask

  // Scoreboard monitor: score handshakes, drop in-flight entries on
  // flush/reset, then record this cycle's accept.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (out_valid === 1'b1) begin
      vld_run++;
      if (vld_run > max_run) max_run = vld_run;
    end else begin
      vld_run = 0;
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got tag %0d expected no output", out_tag);
      end else begin
        e = sb.pop_front();
        check("out_tag", 64'(out_tag), 64'(e.tag));
        check("out_taken", 64'(out_taken), 64'(e.taken));
        check("out_mispredict", 64'(out_mispredict), 64'(e.mis));
        check("out_illegal", 64'(out_illegal), 64'(e.ill));
        if (e.lat) check("latency", 64'(ncyc - e.acc_cyc), 64'(2));
      end
    end
    if (rst_n !== 1'b1 || flush === 1'b1) begin
      sb.delete();
    end else if (in_valid === 1'b1 && in_ready === 1'b1) begin
      e.taken   = cur_exp[2];
      e.ill     = cur_exp[1];
      e.mis     = cur_exp[0];
      e.tag     = in_tag;
      e.acc_cyc = ncyc;
      e.lat     = lat_chk;
      sb.push_back(e);
      acc_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [2:0]      f3;
    logic            p;

    rst_n = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0;
    in_pred_taken = 1'b0; in_tag = '0; flush = 1'b0; out_ready = 1'b1;
`ifdef BRU_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{32'h0000_0005, 32'h0000_0005, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{32'h0000_0005, 32'h0000_0005, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{32'h0000_0003, 32'h0000_0005, 3'b110, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{32'h8000_0000, 32'h7FFF_FFFF, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{32'h8000_0000, 32'h7FFF_FFFF, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{32'h0000_0005, 32'h0000_0006, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state
    step(); step();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_taken", 64'(out_taken), 64'(0));
    check("rst_out_mispredict", 64'(out_mispredict), 64'(0));
    check("rst_out_illegal", 64'(out_illegal), 64'(0));
    check("rst_out_tag", 64'(out_tag), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
`ifdef BRU_PERF_CNT_EN
    check("rst_perf_resolved", 64'(perf_resolved), 64'(0));
    check("rst_perf_mispred", 64'(perf_mispred), 64'(0));
`endif
    rst_n = 1'b1;
    step();

    // Directed table, one branch at a time, latency checked
    lat_chk = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].pred, TAG_W'(i),
            {vecs[i].taken, vecs[i].ill, vecs[i].mis});
      step();
      in_valid = 1'b0;
      repeat (3) step();
    end

    // Back-to-back stream of 8, tags 0..7
    max_run = 0;
    for (int i = 0; i < 8; i++) begin
      a  = $urandom;
      b  = (i % 2 == 1) ? a : $urandom;
      f3 = legal_f3[$urandom_range(0, 5)];
      p  = 1'($urandom_range(0, 1));
      drive(a, b, f3, p, TAG_W'(i), model(a, b, f3, p));
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    check("b2b_out_valid_run", 64'(max_run), 64'(8));

    // Backpressure: two accepts fill the pipe, then stall
    lat_chk = 1'b0;
    acc_cnt = 0;
    out_ready = 1'b0;
    drive(32'd1, 32'd2, 3'b110, 1'b0, TAG_W'(10), model(32'd1, 32'd2, 3'b110, 1'b0));
    step();
    drive(32'd7, 32'd7, 3'b000, 1'b1, TAG_W'(11), model(32'd7, 32'd7, 3'b000, 1'b1));
    step();
    drive(32'd9, 32'd4, 3'b100, 1'b1, TAG_W'(12), model(32'd9, 32'd4, 3'b100, 1'b1));
    for (int k = 0; k < 4; k++) begin
      check("stall_in_ready", 64'(in_ready), 64'(0));
      check("stall_out_valid", 64'(out_valid), 64'(1));
      check("stall_out_tag", 64'(out_tag), 64'(10));
      check("stall_out_taken", 64'(out_taken), 64'(1));
      check("stall_out_mispredict", 64'(out_mispredict), 64'(1));
      step();
    end
    check("stall_accepts", 64'(acc_cnt), 64'(2));
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    check("stall_drain_accepts", 64'(acc_cnt), 64'(3));

    // Flush with S1 and S2 full plus a same-cycle input
    drive(32'd1, 32'd1, 3'b001, 1'b0, TAG_W'(20), model(32'd1, 32'd1, 3'b001, 1'b0));
    step();
    drive(32'd2, 32'd1, 3'b111, 1'b0, TAG_W'(21), model(32'd2, 32'd1, 3'b111, 1'b0));
    step();
    drive(32'd3, 32'd1, 3'b101, 1'b0, TAG_W'(22), model(32'd3, 32'd1, 3'b101, 1'b0));
    flush = 1'b1;
    check("flush_in_ready", 64'(in_ready), 64'(1));
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("post_flush_out_valid", 64'(out_valid), 64'(0));
      step();
    end
    lat_chk = 1'b1;
    drive(32'hFFFF_FFF0, 32'd1, 3'b100, 1'b0, TAG_W'(23),
          model(32'hFFFF_FFF0, 32'd1, 3'b100, 1'b0));
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check("sb_drained", 64'(sb.size()), 64'(0));

    // Reset asserted mid-stream
    for (int i = 0; i < 4; i++) begin
      drive(32'd1, 32'd2, 3'b001, 1'b0, TAG_W'(30 + i), model(32'd1, 32'd2, 3'b001, 1'b0));
      step();
    end
    rst_n = 1'b0;
    step();
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_out_taken", 64'(out_taken), 64'(0));
    check("midrst_out_mispredict", 64'(out_mispredict), 64'(0));
    check("midrst_out_illegal", 64'(out_illegal), 64'(0));
    check("midrst_out_tag", 64'(out_tag), 64'(0));
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (3) step();

`ifdef BRU_PERF_CNT_EN
    // Counters saturate, then clear beats a same-cycle handshake
    lat_chk = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(32'd1, 32'd2, 3'b001, 1'b0, TAG_W'(i), model(32'd1, 32'd2, 3'b001, 1'b0));
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    check("perf_resolved_sat", 64'(perf_resolved), 64'(4'hF));
    check("perf_mispred_sat", 64'(perf_mispred), 64'(4'hF));
    drive(32'd1, 32'd2, 3'b001, 1'b0, TAG_W'(40), model(32'd1, 32'd2, 3'b001, 1'b0));
    step();
    in_valid = 1'b0;
    step();
    check("clr_out_valid", 64'(out_valid), 64'(1));
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    check("perf_resolved_clr", 64'(perf_resolved), 64'(0));
    check("perf_mispred_clr", 64'(perf_mispred), 64'(0));
    step();
`endif

    check("sb_final_empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
